// File: rtl/irq_controller.sv
// Interrupt source side of the CU handshake: synchronises and edge-detects the
// peripheral lines, latches pending edges and raises one request at a time.
module irq_controller #(
    parameter int unsigned N_SRC       = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_in,
    input  logic [N_SRC-1:0] irq_mask,
    input  logic             int_clr,
    input  logic             in_service,
    input  logic             overrun_clr,
    output logic             intr,
    output logic [2:0]       irq_id,
    output logic [N_SRC-1:0] pending,
    output logic [N_SRC-1:0] overrun,
    output logic             busy
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned ID_W  = 3;

    typedef enum logic [1:0] {IDLE, REQ, ACK, SVC} state_t;

    state_t                              state, state_n;
    logic [SYNC_STAGES-1:0][N_SRC-1:0]   sync_q;
    logic [N_SRC-1:0]                    prev_q;
    logic [CNT_W-1:0]                    cnt, cnt_n;
    logic                                intr_n, busy_n;
    logic [ID_W-1:0]                     irq_id_n, winner;
    logic [N_SRC-1:0]                    pending_n, overrun_n;
    logic [N_SRC-1:0]                    edge_v, clr_v, eligible, id_onehot;

    assign eligible  = pending & ~irq_mask;
    assign id_onehot = N_SRC'(1) << irq_id;
    assign edge_v    = sync_q[SYNC_STAGES-1] & ~prev_q;

    // Lowest eligible index wins
    always_comb begin
        winner = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) winner = ID_W'(i);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            sync_q  <= '0;
            prev_q  <= '0;
            cnt     <= '0;
            intr    <= 1'b0;
            irq_id  <= '0;
            pending <= '0;
            overrun <= '0;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            sync_q  <= {sync_q[SYNC_STAGES-2:0], irq_in};
            prev_q  <= sync_q[SYNC_STAGES-1];
            cnt     <= cnt_n;
            intr    <= intr_n;
            irq_id  <= irq_id_n;
            pending <= pending_n;
            overrun <= overrun_n;
            busy    <= busy_n;
        end
    end

    always_comb begin
        state_n  = state;
        intr_n   = intr;
        irq_id_n = irq_id;
        cnt_n    = cnt;
        clr_v    = '0;
        case (state)
            IDLE: begin
                if ((eligible != '0) && !in_service) begin
                    state_n  = REQ;
                    intr_n   = 1'b1;
                    irq_id_n = winner;
                end
            end
            REQ: begin
                // Acknowledge takes precedence over a late mask of the granted source
                if (int_clr) begin
                    clr_v   = id_onehot;
                    intr_n  = 1'b0;
                    cnt_n   = '0;
                    state_n = ACK;
                end else if ((irq_mask & id_onehot) != '0) begin
                    intr_n  = 1'b0;
                    state_n = IDLE;
                end
            end
            ACK: begin
                if (in_service) begin
                    state_n = SVC;
                end else if (cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            SVC: begin
                if (!in_service) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        // Set beats clear; a new edge on an already pending source is an overrun
        pending_n = edge_v | (pending & ~clr_v);
        overrun_n = (edge_v & pending & ~clr_v) | (overrun_clr ? '0 : overrun);
        busy_n    = (state_n != IDLE);
    end

endmodule
